// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, opcodes, ALU codes, field positions and sequencer states
package alu_pkg;

  localparam int DATA_W = 18;
  localparam int REG_AW = 4;

  localparam logic [2:0] ALU_IDLE = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_NAND = 3'b101;
  localparam logic [2:0] ALU_NOR  = 3'b110;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_ANDI = 4'b0011;
  localparam logic [3:0] OP_NAND = 4'b0100;
  localparam logic [3:0] OP_NOR  = 4'b0101;

  localparam int OPC_HI = 17;
  localparam int OPC_LO = 14;
  localparam int RD_HI  = 13;
  localparam int RD_LO  = 10;
  localparam int RS1_HI = 9;
  localparam int RS1_LO = 6;
  localparam int RS2_HI = 5;
  localparam int RS2_LO = 2;
  localparam int IMM_HI = 5;
  localparam int IMM_LO = 0;

  typedef enum logic [2:0] {IDLE, READ, EXEC, WB, ERR} state_t;

  function automatic logic [DATA_W-1:0] sext_imm(input logic [5:0] imm);
    return {{(DATA_W-6){imm[5]}}, imm};
  endfunction

endpackage

// File: rtl/alu_instr_decode.sv
// rtl/alu_instr_decode.sv - opcode to ALU control, immediate select and legality
module alu_instr_decode
  import alu_pkg::*;
(
  input  logic [3:0] opcode,
  output logic [2:0] alu_control,
  output logic       uses_imm,
  output logic       legal
);

  always_comb begin
    alu_control = ALU_IDLE;
    uses_imm    = 1'b0;
    legal       = 1'b1;
    case (opcode)
      OP_ADD:  alu_control = ALU_ADD;
      OP_ADDI: begin alu_control = ALU_ADD; uses_imm = 1'b1; end
      OP_AND:  alu_control = ALU_AND;
      OP_ANDI: begin alu_control = ALU_AND; uses_imm = 1'b1; end
      OP_NAND: alu_control = ALU_NAND;
      OP_NOR:  alu_control = ALU_NOR;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multi-cycle issue controller: read, execute, write back, hold flags
module alu_sequencer
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [DATA_W-1:0] instr,
  output logic [REG_AW-1:0] rf_raddr_a,
  output logic [REG_AW-1:0] rf_raddr_b,
  input  logic [DATA_W-1:0] rf_rdata_a,
  input  logic [DATA_W-1:0] rf_rdata_b,
  output logic [2:0]        alu_control,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_negative,
  input  logic              alu_carry,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_c,
  output logic              busy,
  output logic              done,
  output logic              illegal
);

  state_t              state;
  logic [2:0]          dec_control;
  logic                dec_uses_imm;
  logic                dec_legal;
  logic [2:0]          ctrl_q;
  logic                uses_imm_q;
  logic [5:0]          imm_q;
  logic [REG_AW-1:0]   rd_q;

  alu_instr_decode u_decode (
    .opcode      (instr[OPC_HI:OPC_LO]),
    .alu_control (dec_control),
    .uses_imm    (dec_uses_imm),
    .legal       (dec_legal)
  );

  assign instr_ready = (state == IDLE) && rst_n;

  // Operands come straight from the register file, whose data only lands in EXEC.
  assign alu_a = (state == EXEC) ? rf_rdata_a : '0;
  assign alu_b = (state != EXEC) ? '0 : (uses_imm_q ? sext_imm(imm_q) : rf_rdata_b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      rf_raddr_a  <= '0;
      rf_raddr_b  <= '0;
      alu_control <= ALU_IDLE;
      ctrl_q      <= ALU_IDLE;
      uses_imm_q  <= 1'b0;
      imm_q       <= '0;
      rd_q        <= '0;
      rf_we       <= 1'b0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
      flag_z      <= 1'b0;
      flag_n      <= 1'b0;
      flag_c      <= 1'b0;
      done        <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid) begin
            busy       <= 1'b1;
            ctrl_q     <= dec_control;
            uses_imm_q <= dec_uses_imm;
            imm_q      <= instr[IMM_HI:IMM_LO];
            rd_q       <= instr[RD_HI:RD_LO];
            if (dec_legal) begin
              state      <= READ;
              rf_raddr_a <= instr[RS1_HI:RS1_LO];
              rf_raddr_b <= instr[RS2_HI:RS2_LO];
            end else begin
              state   <= ERR;
              illegal <= 1'b1;
            end
          end
        end
        READ: begin
          state       <= EXEC;
          rf_raddr_a  <= '0;
          rf_raddr_b  <= '0;
          alu_control <= ctrl_q;
        end
        EXEC: begin
          state       <= WB;
          alu_control <= ALU_IDLE;
          rf_we       <= 1'b1;
          rf_waddr    <= rd_q;
          rf_wdata    <= alu_result;
          flag_z      <= alu_zero;
          flag_n      <= alu_negative;
          flag_c      <= alu_carry;
          done        <= 1'b1;
        end
        WB: begin
          state    <= IDLE;
          rf_we    <= 1'b0;
          rf_waddr <= '0;
          rf_wdata <= '0;
          done     <= 1'b0;
          busy     <= 1'b0;
        end
        ERR: begin
          state   <= IDLE;
          illegal <= 1'b0;
          busy    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - scoreboard bench with register file and ALU models around alu_sequencer
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid;
  logic        instr_ready;
  logic [17:0] instr;
  logic [3:0]  rf_raddr_a, rf_raddr_b;
  logic [17:0] rf_rdata_a, rf_rdata_b;
  logic [2:0]  alu_control;
  logic [17:0] alu_a, alu_b, alu_result;
  logic        alu_zero, alu_negative, alu_carry;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [17:0] rf_wdata;
  logic        flag_z, flag_n, flag_c;
  logic        busy, done, illegal;
  logic [2:0]  flags;

  int checks = 0;
  int errors = 0;

  logic [17:0] tb_rf [16];
  logic        pl_en = 1'b0;
  logic [3:0]  pl_addr = '0;
  logic [17:0] pl_data = '0;

  logic [17:0] ref_regs [16];
  logic [2:0]  ref_flags;

  typedef struct {
    bit          ill;
    logic [3:0]  rd;
    logic [17:0] wd;
    logic [2:0]  fl;
  } exp_t;
  exp_t exp_q[$];

  alu_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .rf_raddr_a   (rf_raddr_a),
    .rf_raddr_b   (rf_raddr_b),
    .rf_rdata_a   (rf_rdata_a),
    .rf_rdata_b   (rf_rdata_b),
    .alu_control  (alu_control),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero),
    .alu_negative (alu_negative),
    .alu_carry    (alu_carry),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .flag_z       (flag_z),
    .flag_n       (flag_n),
    .flag_c       (flag_c),
    .busy         (busy),
    .done         (done),
    .illegal      (illegal)
  );

  assign flags = {flag_z, flag_n, flag_c};

  always #5 clk = ~clk;

  // Register file with one-cycle synchronous read; the bench preloads through pl_*.
  always @(posedge clk) begin
    rf_rdata_a <= tb_rf[rf_raddr_a];
    rf_rdata_b <= tb_rf[rf_raddr_b];
    if (rf_we) tb_rf[rf_waddr] <= rf_wdata;
    else if (pl_en) tb_rf[pl_addr] <= pl_data;
  end

  always_comb begin
    alu_result = '0;
    alu_carry  = 1'b0;
    case (alu_control)
      3'b001: {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
      3'b011: alu_result = alu_a & alu_b;
      3'b101: alu_result = ~(alu_a & alu_b);
      3'b110: alu_result = ~(alu_a | alu_b);
      default: ;
    endcase
    alu_zero     = (alu_result == 18'd0);
    alu_negative = alu_result[17];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rf_we || done || illegal) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: rf_we=%0b done=%0b illegal=%0b with nothing expected at %0t",
                 rf_we, done, illegal, $time);
      end else begin
        e = exp_q.pop_front();
        if (e.ill) begin
          chk("mon_illegal", illegal, 1);
          chk("mon_ill_no_we", rf_we, 0);
          chk("mon_ill_no_done", done, 0);
          chk("mon_ill_flags", flags, e.fl);
        end else begin
          chk("mon_we", rf_we, 1);
          chk("mon_done", done, 1);
          chk("mon_no_illegal", illegal, 0);
          chk("mon_waddr", rf_waddr, e.rd);
          chk("mon_wdata", rf_wdata, e.wd);
          chk("mon_flags", flags, e.fl);
        end
      end
    end
  end

  task automatic preload(input logic [3:0] ad, input logic [17:0] d);
    pl_addr = ad;
    pl_data = d;
    pl_en   = 1'b1;
    @(posedge clk);
    #1;
    pl_en = 1'b0;
    ref_regs[ad] = d;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!instr_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic issue(input logic [17:0] ins);
    exp_t        e;
    logic [3:0]  op;
    logic [17:0] a, b, r;
    logic [18:0] sum;
    logic [2:0]  code;
    op   = ins[17:14];
    e.rd = ins[13:10];
    a    = ref_regs[ins[9:6]];
    b    = (op == 4'd1 || op == 4'd3) ? {{12{ins[5]}}, ins[5:0]} : ref_regs[ins[5:2]];
    e.ill = (op > 4'd5);
    sum  = {1'b0, a} + {1'b0, b};
    code = 3'b000;
    r    = '0;
    case (op)
      4'd0, 4'd1: begin code = 3'b001; r = sum[17:0]; end
      4'd2, 4'd3: begin code = 3'b011; r = a & b; end
      4'd4:       begin code = 3'b101; r = ~(a & b); end
      4'd5:       begin code = 3'b110; r = ~(a | b); end
      default: ;
    endcase
    if (!e.ill) begin
      ref_flags = {r == 18'd0, r[17], (op <= 4'd1) ? sum[18] : 1'b0};
      ref_regs[e.rd] = r;
    end
    e.wd = r;
    e.fl = ref_flags;

    instr       = ins;
    instr_valid = 1'b1;
    wait_ready();
    if (!instr_ready) begin
      chk("accept_timeout", instr_ready, 1);
      instr_valid = 1'b0;
      return;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr       = 18'($urandom);
    if (e.ill) begin
      chk("ill_t1_pulse", illegal, 1);
      chk("ill_t1_ready", instr_ready, 0);
      @(posedge clk);
      #1;
      chk("ill_t2_ready", instr_ready, 1);
    end else begin
      chk("t1_busy", busy, 1);
      chk("t1_ready", instr_ready, 0);
      chk("t1_alu_idle", alu_control, 0);
      @(posedge clk);
      #1;
      chk("t2_alu_control", alu_control, code);
      chk("t2_alu_a", alu_a, a);
      chk("t2_alu_b", alu_b, b);
      @(posedge clk);
      #1;
      chk("t3_rf_we", rf_we, 1);
      chk("t3_alu_idle", alu_control, 0);
      @(posedge clk);
      #1;
      chk("t4_ready", instr_ready, 1);
      chk("t4_busy", busy, 0);
    end
  endtask

  task automatic abort_in_exec(input logic [17:0] ins);
    instr       = ins;
    instr_valid = 1'b1;
    wait_ready();
    if (!instr_ready) begin
      chk("abort_accept_timeout", instr_ready, 1);
      instr_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(posedge clk);
    #2;
    chk("abort_in_exec", alu_control, 3'b001);
    rst_n = 1'b0;
    #1;
    chk("abort_no_we", rf_we, 0);
    chk("abort_no_done", done, 0);
    chk("abort_flags", flags, 3'b000);
    chk("abort_ready_low", instr_ready, 0);
    chk("abort_busy", busy, 0);
    @(posedge clk);
    #1;
    chk("abort_still_no_we", rf_we, 0);
    rst_n = 1'b1;
    ref_flags = 3'b000;
    #1;
    chk("abort_ready_back", instr_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    instr_valid = 1'b0;
    instr       = '0;
    ref_flags   = 3'b000;
    for (int i = 0; i < 16; i++) preload(4'(i), 18'd0);

    chk("rst_ready", instr_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", flags, 3'b000);
    chk("rst_alu_control", alu_control, 3'b000);
    chk("rst_we", rf_we, 0);
    chk("rst_done", done, 0);
    chk("rst_illegal", illegal, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_ready", instr_ready, 1);

    preload(4'd1, 18'h1FFFF);
    preload(4'd2, 18'h00001);
    issue({4'b0000, 4'd3, 4'd1, 4'd2, 2'b00});
    preload(4'd1, 18'h3FFFF);
    issue({4'b0000, 4'd3, 4'd1, 4'd2, 2'b00});
    preload(4'd1, 18'h00005);
    issue({4'b0001, 4'd4, 4'd1, 6'b111111});
    issue({4'b0101, 4'd5, 4'd0, 4'd0, 2'b00});
    issue({4'b0010, 4'd6, 4'd5, 4'd0, 2'b00});
    issue({4'b1111, 14'h2A5C});
    issue({4'b0100, 4'd1, 4'd1, 4'd2, 2'b00});

    abort_in_exec({4'b0000, 4'd7, 4'd1, 4'd2, 2'b00});
    chk("abort_queue_empty", exp_q.size(), 0);
    issue({4'b0000, 4'd7, 4'd1, 4'd2, 2'b00});

    for (int k = 0; k < 40; k++) begin
      logic [3:0] op;
      if ($urandom_range(0, 3) == 0) preload(4'($urandom_range(0, 15)), 18'($urandom));
      op = 4'($urandom_range(0, 9));
      if (op > 4'd5) op = 4'($urandom_range(6, 15));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      issue({op, 14'($urandom)});
    end

    repeat (6) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle issue controller that drives the 18-bit ALU's control and operand inputs and consumes its flag outputs. It accepts one 18-bit instruction per valid/ready handshake and reads two source registers from the register file. It then runs the ALU, writes the result back, and holds registered Z/N/C condition flags. It sits between the instruction source and the ALU plus register file, and is the initiator side of the ALU control interface.

## Interface
- No parameters. Data width is fixed at 18 and register address width at 4; these come from the shared package.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  sequencer can accept
- instr  in  18  opcode[17:14], rd[13:10], rs1[9:6], rs2[5:2], imm6[5:0]
- rf_raddr_a / rf_raddr_b  out  4  register file read addresses; the register file has 1-cycle synchronous read latency
- rf_rdata_a / rf_rdata_b  in  18  register file read data
- alu_control  out  3  ALU operation select
- alu_a / alu_b  out  18  ALU operands
- alu_result  in  18; alu_zero, alu_negative, alu_carry  in  1 each  ALU outputs
- rf_we  out  1; rf_waddr  out  4; rf_wdata  out  18  register file write port
- flag_z, flag_n, flag_c  out  1 each  registered condition flags
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse on completion
- illegal  out  1  one-cycle pulse on an undefined opcode

## Operation
- Opcodes:
  - 0000 ADD, 0001 ADDI, 0010 AND, 0011 ANDI, 0100 NAND, 0101 NOR.
  - 0110–1111 are illegal.
- ALU codes:
  - ADD = 3'b001, AND = 3'b011, NAND = 3'b101, NOR = 3'b110, idle = 3'b000.
  - ADDI uses ADD; ANDI uses AND.
- Immediate forms use rs1 as operand A. Operand B is imm6 sign-extended to 18 bits; rs2 is ignored.
- FSM states:
  - IDLE: accept on instr_valid && instr_ready, latch the instruction, then decode.
    - Legal opcode → READ.
    - Illegal opcode → ERR.
  - READ: drive rf_raddr_a = rs1 and rf_raddr_b = rs2 → EXEC.
  - EXEC: drive alu_control, alu_a = rf_rdata_a, and alu_b = rf_rdata_b or the sign-extended imm. At the clock edge, capture alu_result and load flag_z/n/c from alu_zero/negative/carry → WB.
  - WB: rf_we = 1, rf_waddr = rd, rf_wdata = captured result, done = 1 → IDLE.
  - ERR: illegal = 1; no write; flags unchanged → IDLE.
- instr_ready = (state == IDLE) && rst_n.
- Outside EXEC: alu_control = 3'b000 and alu_a = alu_b = 0. Outside READ: rf_raddr_* = 0.
- rd = rs1 or rd = rs2 is legal. The write in WB follows the reads in READ, so there is no hazard inside one instruction.
- Carry is meaningful only for ADD and ADDI. The ALU reports 0 for logic ops, and flag_c follows it.
- An instr_valid that is not accepted is never sampled; instr may change freely while instr_ready is low.

## Timing
- Legal instruction accepted at edge T:
  - READ in cycle T+1.
  - EXEC in cycle T+2.
  - WB, with rf_we and done high, in cycle T+3.
  - Flags are visible from cycle T+3.
  - instr_ready is high again in cycle T+4.
- Illegal instruction accepted at edge T: illegal is high in cycle T+1 and instr_ready is high in cycle T+2.
- Throughput is one legal instruction per 4 cycles. No back-to-back accept occurs while busy.
- Reset values: state IDLE, instr_ready 0 while rst_n is low, and all other outputs 0 (flags 000, alu_control 000, rf_we 0, done 0, illegal 0, busy 0).
- Reset asserted in any state aborts immediately: no rf_we, no done, flags cleared. instr_ready returns to 1 once rst_n is released.

## Structure
- Shared package alu_pkg holds:
  - ALU_ADD/AND/NAND/NOR/IDLE codes.
  - OP_* opcode constants.
  - Instruction field positions.
  - DATA_W = 18 and REG_AW = 4.
  - The state enum (IDLE, READ, EXEC, WB, ERR).
- One sub-module, alu_instr_decode (combinational): instr → alu_control, uses_imm, legal.

## Test plan
- Reset, then release → instr_ready = 1, busy = 0, flags 000, alu_control 000, rf_we 0.
- ADD r3, r1, r2 with r1 = 0x1FFFF, r2 = 0x00001:
  - alu_control = 001 in T+2.
  - rf_we in T+3 with waddr 3 and wdata 0x20000.
  - flags z = 0, n = 1, c = 0; done pulses once.
- ADD with r1 = 0x3FFFF, r2 = 0x00001 → wdata 0x00000, z = 1, n = 0, c = 1.
- ADDI r4, r1, imm6 = 6'b111111 with r1 = 0x00005 → alu_b = 0x3FFFF, wdata 0x00004, c = 1, z = 0.
- NOR r5, r0, r0 with r0 = 0 → alu_control = 110, wdata 0x3FFFF, n = 1, c = 0. Then AND r6, r5, r0 → wdata 0, z = 1.
- Opcode 4'b1111 → illegal high in T+1, no rf_we, flags unchanged, instr_ready high in T+2.
- Next ADD with rst_n pulled low during EXEC → no rf_we, no done, flags 000.
